// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and small types used by the VGA
// timing controller. Optional macro used elsewhere: VGA_FRAME_COUNT_EN.
package vga_pkg;

    // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical)
    localparam int H_DISPLAY_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int V_DISPLAY_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;

    localparam int H_TOTAL = H_DISPLAY_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_DISPLAY_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Raster coordinate and 3-bit colour
    typedef logic [9:0] coord_t;
    typedef logic [2:0] rgb3_t;

endpackage

// File: rtl/vga_pixel_div.sv
// Pixel-rate divider: produces a registered one-clock pixel_tick once
// every CLK_DIV system clocks (every clock when CLK_DIV is 1).
module vga_pixel_div
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic pixel_tick_o
);

    // A one-bit counter is kept even for CLK_DIV=1; it then never leaves 0.
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_q, div_d;
    logic          tick_q, tick_d;

    // Next divider value and tick: tick follows the cycle where divider is at its last count
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        tick_d = (div_q == DIV_LAST);
    end

    // Divider and tick registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign pixel_tick_o = tick_q;

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA timing controller: pixel enable, raster counters for the colour
// source, blanked registered colour and sync outputs aligned to it.
// Optional macro VGA_FRAME_COUNT_EN adds an 8-bit FrameCount output.
module vga_sync_ctrl
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = H_DISPLAY_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_DISPLAY = V_DISPLAY_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [9:0] HCount,
    output logic [9:0] VCount,
    input  logic [2:0] rgb_in,
    output logic [2:0] rgb_out,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel_tick,
`ifdef VGA_FRAME_COUNT_EN
    output logic [7:0] FrameCount,
`endif
    output logic       frame_start
);

    localparam int H_TOT = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISPLAY + V_FP + V_SYNC + V_BP;

    // Decode boundaries as 10-bit constants so comparisons stay width-clean
    localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t H_SYNC_S = coord_t'(H_DISPLAY + H_FP);
    localparam coord_t H_SYNC_E = coord_t'(H_DISPLAY + H_FP + H_SYNC);
    localparam coord_t V_SYNC_S = coord_t'(V_DISPLAY + V_FP);
    localparam coord_t V_SYNC_E = coord_t'(V_DISPLAY + V_FP + V_SYNC);

    logic   tick;
    coord_t h_q, h_d;
    coord_t v_q, v_d;
    rgb3_t  rgb_q, rgb_d;
    logic   hs_q, hs_d;
    logic   vs_q, vs_d;
    logic   fs_q;
    logic   wrap;
    logic   vis;
    logic   hs0;
    logic   vs0;

    vga_pixel_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .pixel_tick_o(tick)
    );

    // Stage-0 decode from the current counter values
    always_comb begin
        vis  = (h_q < H_VIS) && (v_q < V_VIS);
        hs0  = !((h_q >= H_SYNC_S) && (h_q < H_SYNC_E));
        vs0  = !((v_q >= V_SYNC_S) && (v_q < V_SYNC_E));
        wrap = tick && (h_q == H_LAST) && (v_q == V_LAST);
    end

    // Raster counter next-state: advance on pixel ticks, wrap line then frame
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    // Output stage next-state: colour is forced to black outside the visible
    // area so an undriven rgb_in during blanking never reaches the pins
    always_comb begin
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (tick) begin
            rgb_d = vis ? rgb_in : 3'b000;
            hs_d  = hs0;
            vs_d  = vs0;
        end
    end

    // Counter, output-stage and frame pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q   <= '0;
            v_q   <= '0;
            rgb_q <= 3'b000;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            fs_q  <= 1'b0;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= wrap;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_cnt_q;

    // Frame counter advances on the same edge that raises frame_start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= 8'd0;
        end else if (wrap) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign FrameCount = frame_cnt_q;
`endif

    assign HCount      = h_q;
    assign VCount      = v_q;
    assign video_on    = vis;
    assign pixel_tick  = tick;
    assign rgb_out     = rgb_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl with a shrunk raster so several frames fit in a
// short run. The reference model works on a linear pixel index and clock
// count, deriving every expected output arithmetically.
module tb_vga_sync_ctrl;

    localparam int D   = 2;
    localparam int HD  = 16;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int HBP = 2;
    localparam int VD  = 8;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int HT  = HD + HFP + HS + HBP;
    localparam int VT  = VD + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic       clk;
    logic       reset_n;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [2:0] rgb_in;
    logic [2:0] rgb_out;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pixel_tick;
    logic       frame_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] frame_count;
`endif

    vga_sync_ctrl #(
        .CLK_DIV  (D),
        .H_DISPLAY(HD),
        .H_FP     (HFP),
        .H_SYNC   (HS),
        .H_BP     (HBP),
        .V_DISPLAY(VD),
        .V_FP     (VFP),
        .V_SYNC   (VS),
        .V_BP     (VBP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .HCount     (h_count),
        .VCount     (v_count),
        .rgb_in     (rgb_in),
        .rgb_out    (rgb_out),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .pixel_tick (pixel_tick),
`ifdef VGA_FRAME_COUNT_EN
        .FrameCount (frame_count),
`endif
        .frame_start(frame_start)
    );

    // Clock: 10 ns period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // Reference model state: clock edges since reset release, pixels advanced,
    // and the expected registered outputs
    int         e;
    int         p;
    logic [2:0] exp_rgb;
    logic       exp_hs;
    logic       exp_vs;
    logic       exp_fs;
    int         frames;

    function automatic bit vis_of(input int q);
        int h = q % HT;
        int v = (q / HT) % VT;
        return (h < HD) && (v < VD);
    endfunction

    function automatic bit hs_of(input int q);
        int h = q % HT;
        return !((h >= HD + HFP) && (h < HD + HFP + HS));
    endfunction

    function automatic bit vs_of(input int q);
        int v = (q / HT) % VT;
        return !((v >= VD + VFP) && (v < VD + VFP + VS));
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h (edge %0d pixel %0d)", tag, obs, exp, e, p);
        end
    endtask

    task automatic model_reset();
        e       = 0;
        p       = 0;
        exp_rgb = 3'b000;
        exp_hs  = 1'b1;
        exp_vs  = 1'b1;
        exp_fs  = 1'b0;
        frames  = 0;
    endtask

    task automatic check_all();
        check("hcount", h_count, 10'(p % HT));
        check("vcount", v_count, 10'((p / HT) % VT));
        check("pixel_tick", {9'd0, pixel_tick}, {9'd0, (e > 0) && (e % D == 0)});
        check("video_on", {9'd0, video_on}, {9'd0, vis_of(p)});
        check("rgb_out", {7'd0, rgb_out}, {7'd0, exp_rgb});
        check("hsync", {9'd0, hsync}, {9'd0, exp_hs});
        check("vsync", {9'd0, vsync}, {9'd0, exp_vs});
        check("frame_start", {9'd0, frame_start}, {9'd0, exp_fs});
`ifdef VGA_FRAME_COUNT_EN
        check("frame_count", {2'd0, frame_count}, 10'(frames % 256));
`endif
    endtask

    // Random colour for the next sampled pixel; X when that pixel is blanked
    task automatic drive_rgb();
        if (!vis_of(p) && ($urandom_range(0, 1) == 1)) rgb_in = 3'bxxx;
        else rgb_in = 3'($urandom_range(0, 7));
    endtask

    // One clock: advance model, then check outputs 1 ns after the edge
    task automatic step();
        logic [2:0] cur;
        bit         adv;
        cur = rgb_in;
        adv = (e > 0) && (e % D == 0);
        @(posedge clk);
        e++;
        exp_fs = 1'b0;
        if (adv) begin
            exp_rgb = vis_of(p) ? cur : 3'b000;
            exp_hs  = hs_of(p);
            exp_vs  = vs_of(p);
            exp_fs  = ((p % FRAME) == FRAME - 1);
            if (exp_fs) frames++;
            p++;
        end
        #1;
        check_all();
        drive_rgb();
    endtask

    initial begin
        bit found;
        model_reset();
        reset_n = 1'b0;
        rgb_in  = 3'b000;

        // Reset held: all outputs at reset values
        #103;
        check_all();

        // Release and run a bit over two frames with random colour
        @(negedge clk);
        reset_n = 1'b1;
        drive_rgb();
        repeat (2 * FRAME * D + 200) step();

        // Walk to a mid-frame pixel, bounded by one frame of clocks
        found = 1'b0;
        for (int i = 0; i < FRAME * D + 4; i++) begin
            step();
            if ((p % HT == 13) && ((p / HT) % VT == 3)) begin
                found = 1'b1;
                break;
            end
        end
        check("midframe_reach", {9'd0, found}, 10'd1);

        // Asynchronous reset between edges: outputs clear without a clock
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();

        // Clocks during reset change nothing
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all();
        end

        // Release; raster restarts at (0,0) and runs two more frames
        @(negedge clk);
        reset_n = 1'b1;
        drive_rgb();
        repeat (2 * FRAME * D + 50) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
